spi_reg_master: RTL and testbench
=================================

Name: spi_reg_master

Overview:
- SPI master that issues single-register write/read transactions to the SPI-slave/register-file domain over csn/sck/mosi/miso.
- Sits in the system-clock domain and is driven by a local controller through a start/busy/done handshake.
- Generates SCK by dividing clk. Mode 0 (CPOL=0, CPHA=0), MSB first.
- Frame is 24 bits: instruction byte (0x02 write, 0x03 read), address byte, data byte.

Parameters:
- SCK_HALF, 2, clk cycles per SCK half-period; legal values ≥1.
- WIDTH, 8, address/data width; frame logic is fixed for 8.

Ports:
- clk  input  1  system clock; all logic on rising edge.
- reset  input  1  synchronous, active-high reset.
- i_start  input  1  request a transaction; accepted only when o_busy=0.
- i_rw  input  1  1=write, 0=read; sampled with i_start.
- i_addr  input  WIDTH  register address; sampled with i_start.
- i_wdata  input  WIDTH  write data; sampled with i_start; ignored for reads.
- o_busy  output  1  high from accept until the done cycle (exclusive).
- o_done  output  1  one-cycle pulse at end of transaction.
- o_rdata  output  WIDTH  read data; updated only on done of a read.
- o_sck  output  1  SPI clock, idles low.
- o_csn  output  1  chip select, active low.
- o_mosi  output  1  serial data to slave.
- i_miso  input  1  serial data from slave.

Behaviour:
- Reset values: o_busy=0, o_done=0, o_rdata=0, o_sck=0, o_csn=1, o_mosi=0, FSM=IDLE.
- Reset asserted mid-frame aborts at once: o_csn=1 and o_sck=0 on the next edge; no o_done.
- Start accept (i_start=1, o_busy=0):
  - Latch shift register = {rw?8'h02:8'h03, i_addr, rw?i_wdata:8'h00}.
  - o_busy=1, o_csn=0, o_mosi=bit23, FSM=CS_SETUP.
  - i_start while busy is ignored, not queued.
- CS_SETUP: hold SCK_HALF cycles, then go to SHIFT.
- SHIFT: 24 SCK periods.
  - Each period is SCK_HALF cycles low, then SCK_HALF cycles high.
  - At each rising SCK edge the master samples i_miso into the rx shift register.
  - At each falling SCK edge the next frame bit is presented on o_mosi.
  - After the 24th falling edge, o_sck=0 and FSM=CS_HOLD.
- CS_HOLD: hold SCK_HALF cycles with csn low, then raise o_csn and go to DONE.
- DONE (1 cycle):
  - o_done=1, o_busy=0, o_mosi=0.
  - For a read, o_rdata = last 8 sampled bits (rx[7:0]).
  - Next state IDLE. A start presented in this cycle is accepted.
- Latency: start-accept edge to o_done rising = (50*SCK_HALF)+1 cycles.
- Bit counter is 5 bits and saturates; no wrap past 24.
- SCK_HALF counter reloads every half-period. SCK_HALF=1 gives SCK = clk/2.
- i_miso is not sampled outside SHIFT.

Optional Feature:
- Macro: SPI_REG_MASTER_VERIFY_EN.
- Enabled:
  - Adds output o_verify_err (1 bit, reset 0).
  - After each write frame, the FSM inserts a GAP of 2*SCK_HALF cycles with csn high, then runs a read frame to the same address. o_busy stays high throughout.
  - o_done pulses only after the read-back frame.
  - o_verify_err is set on that done if readback≠written data, and cleared on the next accepted start.
  - o_rdata is loaded with the readback value.
- Disabled: no o_verify_err port, no GAP state; write frames end as specified above.

Test Plan:
- Reset then idle: o_csn=1, o_sck=0, o_busy=0, o_rdata=0 for 20 cycles. i_start during reset is ignored.
- Write, SCK_HALF=2, addr 0x01, data 0xA5:
  - Slave model captures MOSI 0x02,0x01,0xA5 on rising SCK.
  - Exactly 24 SCK pulses.
  - o_done exactly 101 cycles after accept.
- Read addr 0x04, slave drives 0x3C in the data byte → o_rdata=0x3C at o_done; o_rdata unchanged by a prior write.
- Back-to-back: i_start held high → second frame accepted on the done cycle; csn high exactly for that one cycle between frames. i_start during busy is ignored.
- Reset asserted during bit 10 of SHIFT → next edge csn=1, sck=0, busy=0, no done; a following transaction completes normally.
- VERIFY_EN: write 0x5A, slave returns 0x5B → o_verify_err=1 at done; repeat with matching slave → o_verify_err=0.

Source files
------------

// File: rtl/spi_reg_master.sv
// spi_reg_master: SPI mode-0 master issuing single-register write/read frames.
// Each frame is 24 bits, sent MSB first: instruction (0x02 write, 0x03 read),
// then an address byte, then a data byte.
// SCK is clk divided by 2*SCK_HALF.
// Optional build macro SPI_REG_MASTER_VERIFY_EN adds a read-back check after
// every write and reports the result on o_verify_err.
module spi_reg_master #(
    parameter int unsigned SCK_HALF = 2,
    parameter int unsigned WIDTH    = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_start,
    input  logic             i_rw,
    input  logic [WIDTH-1:0] i_addr,
    input  logic [WIDTH-1:0] i_wdata,
    output logic             o_busy,
    output logic             o_done,
    output logic [WIDTH-1:0] o_rdata,
    output logic             o_sck,
    output logic             o_csn,
    output logic             o_mosi,
    input  logic             i_miso
`ifdef SPI_REG_MASTER_VERIFY_EN
    ,
    output logic             o_verify_err
`endif
);

    localparam int unsigned FRAME_W = 8 + 2 * WIDTH;
    localparam int unsigned TW      = $clog2(2 * SCK_HALF + 1);

    localparam logic [TW-1:0]    HALF     = TW'(SCK_HALF);
    localparam logic [TW-1:0]    HALF_M1  = TW'(SCK_HALF - 1);
    localparam logic [4:0]       LAST_BIT = 5'(FRAME_W - 1);
    localparam logic [4:0]       FULL_BIT = 5'(FRAME_W);
    localparam logic [7:0]       WR_INSTR = 8'h02;
    localparam logic [7:0]       RD_INSTR = 8'h03;
    localparam logic [WIDTH-1:0] ZERO     = '0;
`ifdef SPI_REG_MASTER_VERIFY_EN
    localparam logic [TW-1:0]    GAP_M1   = TW'(2 * SCK_HALF - 1);
`endif

    typedef enum logic [2:0] {
        IDLE,
        CS_SETUP,
        SHIFT,
        CS_HOLD,
        DONE
`ifdef SPI_REG_MASTER_VERIFY_EN
        ,
        GAP
`endif
    } state_t;

    state_t               state_q, state_d;
    logic [TW-1:0]        tmr_q, tmr_d;
    logic                 sck_q, sck_d;
    logic                 csn_q, csn_d;
    logic                 mosi_q, mosi_d;
    logic [4:0]           bit_q, bit_d;
    logic [FRAME_W-1:0]   sr_q, sr_d;
    logic [WIDTH-1:0]     rx_q, rx_d;
    logic [WIDTH-1:0]     rdata_q, rdata_d;
    logic                 frame_rd_q, frame_rd_d;
    logic                 accept;
    logic [FRAME_W-1:0]   start_frame;
`ifdef SPI_REG_MASTER_VERIFY_EN
    logic [WIDTH-1:0]     addr_q, addr_d;
    logic [WIDTH-1:0]     wdata_q, wdata_d;
    logic                 wr_pend_q, wr_pend_d;
    logic                 vchk_q, vchk_d;
    logic                 verr_q, verr_d;
`endif

    // State and datapath registers, synchronous active-high reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            tmr_q      <= '0;
            sck_q      <= 1'b0;
            csn_q      <= 1'b1;
            mosi_q     <= 1'b0;
            bit_q      <= '0;
            sr_q       <= '0;
            rx_q       <= '0;
            rdata_q    <= '0;
            frame_rd_q <= 1'b0;
`ifdef SPI_REG_MASTER_VERIFY_EN
            addr_q     <= '0;
            wdata_q    <= '0;
            wr_pend_q  <= 1'b0;
            vchk_q     <= 1'b0;
            verr_q     <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            tmr_q      <= tmr_d;
            sck_q      <= sck_d;
            csn_q      <= csn_d;
            mosi_q     <= mosi_d;
            bit_q      <= bit_d;
            sr_q       <= sr_d;
            rx_q       <= rx_d;
            rdata_q    <= rdata_d;
            frame_rd_q <= frame_rd_d;
`ifdef SPI_REG_MASTER_VERIFY_EN
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            wr_pend_q  <= wr_pend_d;
            vchk_q     <= vchk_d;
            verr_q     <= verr_d;
`endif
        end
    end

    // Next-state and datapath update: half-period timer, SCK toggling, bit shifting.
    always_comb begin
        state_d    = state_q;
        tmr_d      = tmr_q;
        sck_d      = sck_q;
        csn_d      = csn_q;
        mosi_d     = mosi_q;
        bit_d      = bit_q;
        sr_d       = sr_q;
        rx_d       = rx_q;
        rdata_d    = rdata_q;
        frame_rd_d = frame_rd_q;
`ifdef SPI_REG_MASTER_VERIFY_EN
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        wr_pend_d  = wr_pend_q;
        vchk_d     = vchk_q;
        verr_d     = verr_q;
`endif
        accept      = i_start && (state_q == IDLE || state_q == DONE);
        start_frame = {i_rw ? WR_INSTR : RD_INSTR, i_addr, i_rw ? i_wdata : ZERO};

        unique case (state_q)
            IDLE: state_d = IDLE;
            // The timer is loaded with SCK_HALF rather than SCK_HALF-1.
            // The accept cycle is therefore part of the setup time, so done
            // lands 50*SCK_HALF+1 cycles after accept.
            CS_SETUP: begin
                if (tmr_q == '0) begin
                    state_d = SHIFT;
                    tmr_d   = HALF_M1;
                end else begin
                    tmr_d = tmr_q - 1'b1;
                end
            end
            SHIFT: begin
                if (tmr_q != '0) begin
                    tmr_d = tmr_q - 1'b1;
                end else begin
                    tmr_d = HALF_M1;
                    if (!sck_q) begin
                        sck_d = 1'b1;
                        rx_d  = {rx_q[WIDTH-2:0], i_miso};
                    end else begin
                        sck_d = 1'b0;
                        if (bit_q != FULL_BIT) begin
                            bit_d = bit_q + 1'b1;
                        end
                        if (bit_q == LAST_BIT) begin
                            state_d = CS_HOLD;
                        end else begin
                            sr_d   = {sr_q[FRAME_W-2:0], 1'b0};
                            mosi_d = sr_q[FRAME_W-2];
                        end
                    end
                end
            end
            CS_HOLD: begin
                if (tmr_q == '0) begin
                    csn_d   = 1'b1;
                    mosi_d  = 1'b0;
                    state_d = DONE;
                    if (frame_rd_q) begin
                        rdata_d = rx_q;
                    end
`ifdef SPI_REG_MASTER_VERIFY_EN
                    if (wr_pend_q) begin
                        state_d   = GAP;
                        tmr_d     = GAP_M1;
                        wr_pend_d = 1'b0;
                    end
                    if (vchk_q) begin
                        verr_d = (rx_q != wdata_q);
                    end
`endif
                end else begin
                    tmr_d = tmr_q - 1'b1;
                end
            end
            DONE: state_d = IDLE;
`ifdef SPI_REG_MASTER_VERIFY_EN
            GAP: begin
                if (tmr_q == '0) begin
                    state_d    = CS_SETUP;
                    tmr_d      = HALF;
                    csn_d      = 1'b0;
                    sck_d      = 1'b0;
                    bit_d      = '0;
                    sr_d       = {RD_INSTR, addr_q, ZERO};
                    mosi_d     = RD_INSTR[7];
                    frame_rd_d = 1'b1;
                    vchk_d     = 1'b1;
                end else begin
                    tmr_d = tmr_q - 1'b1;
                end
            end
`endif
            default: state_d = IDLE;
        endcase

        if (accept) begin
            state_d    = CS_SETUP;
            tmr_d      = HALF;
            csn_d      = 1'b0;
            sck_d      = 1'b0;
            bit_d      = '0;
            sr_d       = start_frame;
            mosi_d     = start_frame[FRAME_W-1];
            frame_rd_d = !i_rw;
`ifdef SPI_REG_MASTER_VERIFY_EN
            addr_d     = i_addr;
            wdata_d    = i_wdata;
            wr_pend_d  = i_rw;
            vchk_d     = 1'b0;
            verr_d     = 1'b0;
`endif
        end
    end

    // Output decode: handshake from state, SPI pins straight from registers.
    always_comb begin
        o_busy  = (state_q != IDLE) && (state_q != DONE);
        o_done  = (state_q == DONE);
        o_rdata = rdata_q;
        o_sck   = sck_q;
        o_csn   = csn_q;
        o_mosi  = mosi_q;
`ifdef SPI_REG_MASTER_VERIFY_EN
        o_verify_err = verr_q;
`endif
    end

endmodule

// File: tb/tb_spi_reg_master.sv
// tb_spi_reg_master: directed self-checking bench for spi_reg_master (SCK_HALF=2).
// A mode-0 slave model captures MOSI and drives MISO with {0xC3, 0x81, slave_data}.
module tb_spi_reg_master;

    localparam int H      = 2;
    localparam int RD_LAT = 50 * H + 1;
`ifdef SPI_REG_MASTER_VERIFY_EN
    localparam int WR_LAT = 102 * H + 1;
`else
    localparam int WR_LAT = 50 * H + 1;
`endif

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       i_start = 1'b0;
    logic       i_rw = 1'b0;
    logic [7:0] i_addr = '0;
    logic [7:0] i_wdata = '0;
    logic       o_busy, o_done, o_sck, o_csn, o_mosi;
    logic [7:0] o_rdata;
    logic       miso = 1'b0;
`ifdef SPI_REG_MASTER_VERIFY_EN
    logic       o_verify_err;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    spi_reg_master #(.SCK_HALF(H), .WIDTH(8)) dut (
        .clk     (clk),
        .reset   (reset),
        .i_start (i_start),
        .i_rw    (i_rw),
        .i_addr  (i_addr),
        .i_wdata (i_wdata),
        .o_busy  (o_busy),
        .o_done  (o_done),
        .o_rdata (o_rdata),
        .o_sck   (o_sck),
        .o_csn   (o_csn),
        .o_mosi  (o_mosi),
        .i_miso  (miso)
`ifdef SPI_REG_MASTER_VERIFY_EN
        ,
        .o_verify_err (o_verify_err)
`endif
    );

    always #5 clk = ~clk;

    // Slave model: edges of csn/sck detected at the clk falling edge.
    logic [7:0]  slave_data = 8'h00;
    logic [23:0] s_tx = '0;
    logic [23:0] cap = '0;
    int          sck_pulses = 0;
    logic        prev_csn = 1'b1;
    logic        prev_sck = 1'b0;

    always @(negedge clk) begin
        logic [23:0] f;
        f = {16'hC381, slave_data};
        if (prev_csn && !o_csn) begin
            s_tx       <= f;
            miso       <= f[23];
            cap        <= '0;
            sck_pulses <= 0;
        end else if (!o_csn) begin
            if (!prev_sck && o_sck) begin
                cap        <= {cap[22:0], o_mosi};
                sck_pulses <= sck_pulses + 1;
            end
            if (prev_sck && !o_sck) begin
                s_tx <= {s_tx[22:0], 1'b0};
                miso <= s_tx[22];
            end
        end
        prev_csn <= o_csn;
        prev_sck <= o_sck;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Waits (bounded) for o_done; lat = cycles from accept edge, -1 on timeout.
    task automatic wait_done(input int max_cyc, output int lat);
        lat = -1;
        for (int n = 1; n <= max_cyc; n++) begin
            @(posedge clk);
            #1;
            if (o_done) begin
                lat = n;
                break;
            end
        end
    endtask

    task automatic run_txn(input logic rw, input logic [7:0] addr, input logic [7:0] wdata,
                           output int lat);
        @(negedge clk);
        i_start = 1'b1;
        i_rw    = rw;
        i_addr  = addr;
        i_wdata = wdata;
        @(posedge clk);
        #1;
        i_start = 1'b0;
        wait_done(400, lat);
    endtask

    initial begin
        int lat;
        int dones;

        // Reset with i_start asserted: must be ignored.
        i_start = 1'b1;
        i_rw    = 1'b1;
        repeat (5) @(posedge clk);
        @(negedge clk);
        reset   = 1'b0;
        i_start = 1'b0;
        for (int c = 0; c < 20; c++) begin
            @(posedge clk);
            #1;
            check("idle_csn", o_csn, 1);
            check("idle_sck", o_sck, 0);
            check("idle_busy", o_busy, 0);
            check("idle_rdata", o_rdata, 0);
        end
        check("idle_done", o_done, 0);
        check("idle_mosi", o_mosi, 0);

        // Write 0xA5 to 0x01.
        slave_data = 8'hA5;
        run_txn(1'b1, 8'h01, 8'hA5, lat);
        check("wr_latency", lat, WR_LAT);
        check("wr_busy_at_done", o_busy, 0);
        check("wr_csn_at_done", o_csn, 1);
        check("wr_pulses", sck_pulses, 24);
`ifdef SPI_REG_MASTER_VERIFY_EN
        check("wr_cap", cap, 24'h030100);
        check("wr_verr", o_verify_err, 0);
`else
        check("wr_cap", cap, 24'h0201A5);
        check("wr_rdata_untouched", o_rdata, 0);
`endif

        // Read 0x04, slave returns 0x3C.
        slave_data = 8'h3C;
        run_txn(1'b0, 8'h04, 8'hFF, lat);
        check("rd_latency", lat, RD_LAT);
        check("rd_cap", cap, 24'h030400);
        check("rd_pulses", sck_pulses, 24);
        check("rd_rdata", o_rdata, 8'h3C);

        // Write afterwards leaves o_rdata alone (verify build reloads with readback).
        slave_data = 8'h66;
        run_txn(1'b1, 8'h07, 8'h11, lat);
        check("wr2_latency", lat, WR_LAT);
`ifdef SPI_REG_MASTER_VERIFY_EN
        check("wr2_rdata", o_rdata, 8'h66);
`else
        check("wr2_rdata", o_rdata, 8'h3C);
        check("wr2_cap", cap, 24'h020711);
`endif

        // Back-to-back with i_start held; inputs changed while busy.
        slave_data = 8'h9E;
        @(negedge clk);
        i_start = 1'b1;
        i_rw    = 1'b1;
        i_addr  = 8'h10;
        i_wdata = 8'h77;
        @(posedge clk);
        #1;
        check("b2b_busy", o_busy, 1);
        i_rw    = 1'b0;
        i_addr  = 8'h20;
        i_wdata = 8'h99;
        wait_done(400, lat);
        check("b2b_lat1", lat, WR_LAT);
        check("b2b_csn_gap", o_csn, 1);
`ifdef SPI_REG_MASTER_VERIFY_EN
        check("b2b_cap1", cap, 24'h031000);
`else
        check("b2b_cap1", cap, 24'h021077);
`endif
        @(posedge clk);
        #1;
        check("b2b_csn_low", o_csn, 0);
        check("b2b_accept2", o_busy, 1);
        i_start = 1'b0;
        wait_done(400, lat);
        check("b2b_lat2", lat, RD_LAT);
        check("b2b_cap2", cap, 24'h032000);
        check("b2b_rdata", o_rdata, 8'h9E);
        @(posedge clk);
        #1;
        check("b2b_not_queued", o_busy, 0);
        check("b2b_csn_idle", o_csn, 1);

        // Reset during bit 10 of SHIFT.
        @(negedge clk);
        i_start = 1'b1;
        i_rw    = 1'b1;
        i_addr  = 8'h55;
        i_wdata = 8'hAA;
        @(posedge clk);
        #1;
        i_start = 1'b0;
        lat = -1;
        for (int n = 0; n < 200; n++) begin
            @(posedge clk);
            #1;
            if (sck_pulses >= 10) begin
                lat = n;
                break;
            end
        end
        check("rst_reach_bit10", (lat >= 0) ? 1 : 0, 1);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        check("rst_csn", o_csn, 1);
        check("rst_sck", o_sck, 0);
        check("rst_busy", o_busy, 0);
        check("rst_done", o_done, 0);
        @(negedge clk);
        reset = 1'b0;
        dones = 0;
        for (int n = 0; n < 120; n++) begin
            @(posedge clk);
            #1;
            if (o_done) dones++;
        end
        check("rst_no_done", dones, 0);
        slave_data = 8'hE7;
        run_txn(1'b0, 8'h04, 8'h00, lat);
        check("post_rst_lat", lat, RD_LAT);
        check("post_rst_rdata", o_rdata, 8'hE7);
        check("post_rst_cap", cap, 24'h030400);

`ifdef SPI_REG_MASTER_VERIFY_EN
        slave_data = 8'h5B;
        run_txn(1'b1, 8'h33, 8'h5A, lat);
        check("ver_bad_lat", lat, WR_LAT);
        check("ver_bad_err", o_verify_err, 1);
        check("ver_bad_rdata", o_rdata, 8'h5B);
        slave_data = 8'h5A;
        run_txn(1'b1, 8'h33, 8'h5A, lat);
        check("ver_ok_lat", lat, WR_LAT);
        check("ver_ok_err", o_verify_err, 0);
        check("ver_ok_rdata", o_rdata, 8'h5A);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
